mips_multicycle_fsm: RTL
========================

// Module: mips_multicycle_fsm
// PURPOSE
//  Multicycle control sequencer for the MIPS datapath. Owns the instruction-phase
//  state register, stretches memory phases for read latency, and drives every
//  datapath enable/select (PC, IR, register file, ALU muxes, memory).
//  Sits beside the datapath in mips_module; it replaces the free-running state
//  chain and the combinational control decode.
// PARAMETERS
//  MEM_LATENCY  2  memory read latency in cycles after address is presented (0..7)
// PORTS
//  clk          in   1   system clock, rising edge
//  rstb         in   1   asynchronous reset, active low
//  opcode       in   6   IR[31:26], valid from DECODE onward
//  funct        in   6   IR[5:0]
//  alu_zero     in   1   ALU zero flag of current ALU result
//  pc_write     out  1   load PC from pc_src mux
//  ir_write     out  1   load IR from read_data
//  reg_write    out  1   register file write enable
//  reg_dst      out  1   0=rt, 1=rd as write address
//  mem_to_reg   out  1   0=ALUOut, 1=MDR as write data
//  i_or_d       out  1   memory address: 0=PC, 1=ALUOut
//  mem_wr_ena   out  1   memory write strobe
//  alu_src_a    out  1   0=PC, 1=regD1
//  alu_src_b    out  2   00=regD2, 01=4, 10=ext imm, 11=sext imm<<2
//  imm_zext     out  1   1=zero-extend imm (andi/ori/xori), else sign-extend
//  alu_control  out  4   AND 0000 OR 0001 XOR 0010 NOR 0011 ADD 0101 SUB 0110
//                        SLT 0111 SRL 1000 SLL 1001 SRA 1010
//  pc_src       out  2   00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}
//  state        out  4   current state (debug/bench)
//  halted       out  1   sticky, illegal opcode seen
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low on rstb. Reset: state=FETCH,
//    wait_cnt=0, halted=0; every output is Moore-decoded from state, so all
//    enables are 0 except FETCH's i_or_d=0, alu_src_a=0, alu_src_b=01, ADD.
//  - Encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WR 4, WB_MEM 5,
//    EXEC_R 6, EXEC_I 7, WB_ALU 8, BRANCH 9, JUMP 10, HALT 15.
//  - FETCH: i_or_d=0; held MEM_LATENCY+1 cycles via wait_cnt (cleared on entry).
//    Final cycle only: ir_write=1, pc_write=1, pc_src=00, PC+4. Then DECODE.
//  - DECODE (1 cycle): ALU=PC+(sext imm<<2) into ALUOut (branch target).
//    Next: 0x00 R-type->EXEC_R; 0x23/0x2b->MEM_ADDR; 0x04/0x05->BRANCH;
//    0x08/0x0a/0x0c/0x0d/0x0e->EXEC_I; 0x02/0x03->JUMP; other->HALT.
//  - EXEC_R: src_a=1, src_b=00; funct 20 ADD,22 SUB,24 AND,25 OR,26 XOR,27 NOR,
//    2A SLT,00 SLL,02 SRL,03 SRA; unknown funct->HALT. Next WB_ALU.
//  - EXEC_I: src_a=1, src_b=10; 08 ADD,0A SLT,0C AND,0D OR,0E XOR; imm_zext=1
//    for 0C/0D/0E. Next WB_ALU.
//  - WB_ALU: reg_write=1; reg_dst=1 if R-type else 0; mem_to_reg=0. Next FETCH.
//  - MEM_ADDR: src_a=1, src_b=10, ADD. Next MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD: i_or_d=1; held MEM_LATENCY+1 cycles. Next WB_MEM.
//  - MEM_WR: i_or_d=1, mem_wr_ena=1 for exactly 1 cycle. Next FETCH.
//  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
//  - BRANCH: src_a=1, src_b=00, SUB; pc_src=01; pc_write=alu_zero (beq) or
//    !alu_zero (bne); only Mealy output. Next FETCH.
//  - JUMP: pc_src=10, pc_write=1. jal: also reg_write of return address is
//    out of scope, treated as j. Next FETCH.
//  - HALT: all enables 0, halted=1; leaves only on reset.
//  - Latency (L=MEM_LATENCY): R/I-ALU L+4, lw 2L+5, sw L+4, beq/bne/j L+3.
//  - wait_cnt is 3 bits, saturating; never wraps through a phase.
//  - Reset asserted mid-instruction: immediate return to FETCH; no partial
//    write enable may be seen after rstb falls.
//  - pc_write, ir_write, reg_write, mem_wr_ena: never more than one asserted
//    except FETCH final cycle (pc_write+ir_write).
// TESTING
//  1 L=2, add (op 00,f 20): FETCH 3 cyc, ir_write+pc_write on cyc 3, EXEC_R alu 0101,
//    WB_ALU reg_write=1 reg_dst=1; total 6 cycles.
//  2 L=2, lw (op 23): MEM_RD held 3 cycles with i_or_d=1; WB_MEM mem_to_reg=1;
//    total 9 cycles; sw (2b): mem_wr_ena high exactly 1 cycle, total 6.
//  3 beq alu_zero=1 -> pc_write=1 pc_src=01; alu_zero=0 -> pc_write=0; bne reversed.
//  4 opcode 3F -> HALT, halted=1, no enables for 20 cycles; rstb low -> FETCH, halted=0.
//  5 rstb low during MEM_RD -> state=0 asynchronously, reg_write never pulses.
//  6 L=0: add in 4 cycles, lw in 5; andi (0C) imm_zext=1, alu 0000.

Source files
------------

// File: rtl/mips_multicycle_fsm.sv
// Multicycle MIPS control sequencer: phase state register, memory-latency stretching,
// and Moore-decoded datapath enables/selects (branch pc_write is the only Mealy output).
`timescale 1ns/1ps
module mips_multicycle_fsm #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       i_or_d,
  output logic       mem_wr_ena,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [3:0] alu_control,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WR   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [2:0] LAT     = 3'(MEM_LATENCY);

  state_t     cur, nxt;
  logic [2:0] wait_cnt;
  logic       phase_done;
  logic       r_ok;
  logic [3:0] r_alu;
  logic [3:0] i_alu;

  assign phase_done = (wait_cnt == LAT);
  assign state      = cur;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    unique case (funct)
      6'h20: r_alu = ALU_ADD;
      6'h22: r_alu = ALU_SUB;
      6'h24: r_alu = ALU_AND;
      6'h25: r_alu = ALU_OR;
      6'h26: r_alu = ALU_XOR;
      6'h27: r_alu = ALU_NOR;
      6'h2a: r_alu = ALU_SLT;
      6'h00: r_alu = ALU_SLL;
      6'h02: r_alu = ALU_SRL;
      6'h03: r_alu = ALU_SRA;
      default: r_ok = 1'b0;
    endcase
    i_alu = ALU_ADD;
    case (opcode)
      6'h0a:   i_alu = ALU_SLT;
      6'h0c:   i_alu = ALU_AND;
      6'h0d:   i_alu = ALU_OR;
      6'h0e:   i_alu = ALU_XOR;
      default: i_alu = ALU_ADD;
    endcase
  end

  // wait_cnt restarts on every state change and saturates while a phase is held
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (phase_done) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:                             nxt = S_EXEC_R;
          6'h23, 6'h2b:                      nxt = S_MEM_ADDR;
          6'h04, 6'h05:                      nxt = S_BRANCH;
          6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: nxt = S_EXEC_I;
          6'h02, 6'h03:                      nxt = S_JUMP;
          default:                           nxt = S_HALT;
        endcase
      end
      S_EXEC_R:   nxt = r_ok ? S_WB_ALU : S_HALT;
      S_EXEC_I:   nxt = S_WB_ALU;
      S_MEM_ADDR: nxt = (opcode == 6'h2b) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (phase_done) nxt = S_WB_MEM;
      S_MEM_WR, S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: nxt = S_FETCH;
      default:    nxt = S_HALT;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    i_or_d      = 1'b0;
    mem_wr_ena  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    imm_zext    = 1'b0;
    alu_control = ALU_ADD;
    pc_src      = 2'b00;
    halted      = 1'b0;
    case (cur)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = phase_done;
        pc_write  = phase_done;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: i_or_d = 1'b1;
      S_MEM_WR: begin
        i_or_d     = 1'b1;
        mem_wr_ena = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
      end
      S_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = i_alu;
        imm_zext    = (opcode == 6'h0c) || (opcode == 6'h0d) || (opcode == 6'h0e);
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == 6'h00);
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = (opcode == 6'h04) ? alu_zero : !alu_zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

endmodule
